mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline buffer and the WB stage. It turns the buffered load/store into a req/ack transaction on the data-memory port, and formats byte/halfword/word data in both directions. It raises a stall to the hazard unit while memory is busy, then registers the result into the MEM/WB boundary.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/load_align.sv | 27 ++
 rtl/mem_access_stage.sv | 132 +++++++++++++
 tb/tb_mem_access_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage: opcodes, funct3 codes,
// FSM state encodings and the access-legality helper.
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // An access is bad when funct3 is illegal for its direction or the address
    // is not naturally aligned for the access size.
    function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic legal;
        logic misaligned;
        if (is_store)
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return !legal || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// Read-data formatter: picks the byte/halfword lane by address and
// sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [15:0] lane;

    assign lane = 16'(rdata >> {addr, 3'b000});

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{lane[7]}}, lane[7:0]};
            F3_H:    result = {{16{lane[15]}}, lane};
            F3_BU:   result = {24'h0, lane[7:0]};
            F3_HU:   result = {16'h0, lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data-memory port, formats store and load data,
// stalls the pipeline while memory is busy and registers results into MEM/WB.
//
// state   | meaning
// IDLE    | no outstanding request; new access may issue this cycle
// WAIT    | request outstanding, waiting for dmem_ack
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       MEM_ALU_OUT,
    input  logic [31:0]       MEM_rs2,
    input  logic [4:0]        MEM_rd_ind,
    input  logic [31:0]       MEM_PC,
    input  logic [31:0]       MEM_INST,
    input  logic [6:0]        MEM_opcode,
    input  logic              MEM_memread,
    input  logic              MEM_memwrite,
    input  logic              MEM_regwrite,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              MEM_STALL,
    output logic              MEM_EXC,
    output logic [31:0]       WB_ALU_OUT,
    output logic [31:0]       WB_MEM_OUT,
    output logic [31:0]       WB_PC,
    output logic [31:0]       WB_INST,
    output logic [4:0]        WB_rd_ind,
    output logic              WB_regwrite,
    output logic              WB_memread
);

    logic [0:0]  state;
    logic [2:0]  funct3;
    logic        mem_op;
    logic        is_store;
    logic        is_load;
    logic        bad;
    logic        req_raw;
    logic [31:0] load_data;

    assign funct3   = MEM_INST[14:12];
    assign mem_op   = MEM_memread | MEM_memwrite;
    // mem_op qualifies an access; the opcode tells a store from a load.
    assign is_store = mem_op & (MEM_opcode == OP_STORE);
    assign is_load  = mem_op & !is_store;
    assign bad      = mem_op & access_bad(is_store, funct3, MEM_ALU_OUT[1:0]);

    assign req_raw   = ((state == ST_IDLE) & mem_op & !bad) | (state == ST_WAIT);
    // Reset abandons any outstanding request at once, without waiting for a clock.
    assign dmem_req  = rst & req_raw;
    assign MEM_STALL = dmem_req & !dmem_ack;
    assign dmem_we   = is_store;
    assign dmem_addr = ADDR_W'({MEM_ALU_OUT[31:2], 2'b00});

    always_comb begin
        dmem_be    = 4'hF;
        dmem_wdata = MEM_rs2;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    dmem_be    = 4'b0001 << MEM_ALU_OUT[1:0];
                    dmem_wdata = {4{MEM_rs2[7:0]}};
                end
                F3_H: begin
                    dmem_be    = 4'b0011 << MEM_ALU_OUT[1:0];
                    dmem_wdata = {2{MEM_rs2[15:0]}};
                end
                default: begin
                    dmem_be    = 4'hF;
                    dmem_wdata = MEM_rs2;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (MEM_ALU_OUT[1:0]),
        .funct3 (funct3),
        .result (load_data)
    );

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            MEM_EXC     <= 1'b0;
            WB_ALU_OUT  <= '0;
            WB_MEM_OUT  <= '0;
            WB_PC       <= '0;
            WB_INST     <= '0;
            WB_rd_ind   <= '0;
            WB_regwrite <= 1'b0;
            WB_memread  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (dmem_req && !dmem_ack) state <= ST_WAIT;
                default: if (dmem_ack) state <= ST_IDLE;
            endcase

            // A bad access never issues, so it always commits straight from IDLE.
            MEM_EXC <= bad & (state == ST_IDLE);

            if (MEM_STALL) begin
                WB_ALU_OUT  <= '0;
                WB_MEM_OUT  <= '0;
                WB_PC       <= '0;
                WB_INST     <= '0;
                WB_rd_ind   <= '0;
                WB_regwrite <= 1'b0;
                WB_memread  <= 1'b0;
            end else begin
                WB_ALU_OUT  <= MEM_ALU_OUT;
                WB_MEM_OUT  <= (is_load && !bad) ? load_data : 32'h0;
                WB_PC       <= MEM_PC;
                WB_INST     <= MEM_INST;
                WB_rd_ind   <= MEM_rd_ind;
                WB_regwrite <= MEM_regwrite & !bad & !is_store;
                WB_memread  <= MEM_memread & !bad;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver pushes one expected record per
// cycle from a behavioural model, a monitor pops and compares against the DUT.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] MEM_ALU_OUT, MEM_rs2, MEM_PC, MEM_INST;
    logic [4:0]  MEM_rd_ind;
    logic [6:0]  MEM_opcode;
    logic        MEM_memread, MEM_memwrite, MEM_regwrite;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        MEM_STALL, MEM_EXC;
    logic [31:0] WB_ALU_OUT, WB_MEM_OUT, WB_PC, WB_INST;
    logic [4:0]  WB_rd_ind;
    logic        WB_regwrite, WB_memread;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req, stall, we;
        logic [3:0]  be;
        logic [31:0] wdata, addr, alu, mo, pc, inst;
        logic [4:0]  rd;
        logic        rw, mr, exc;
    } rec_t;

    rec_t q[$];

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .MEM_ALU_OUT(MEM_ALU_OUT), .MEM_rs2(MEM_rs2), .MEM_rd_ind(MEM_rd_ind),
        .MEM_PC(MEM_PC), .MEM_INST(MEM_INST), .MEM_opcode(MEM_opcode),
        .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite), .MEM_regwrite(MEM_regwrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .MEM_STALL(MEM_STALL), .MEM_EXC(MEM_EXC),
        .WB_ALU_OUT(WB_ALU_OUT), .WB_MEM_OUT(WB_MEM_OUT), .WB_PC(WB_PC), .WB_INST(WB_INST),
        .WB_rd_ind(WB_rd_ind), .WB_regwrite(WB_regwrite), .WB_memread(WB_memread)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: combinational port checks mid-cycle, registered WB checks after the edge.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                chk("dmem_req", 32'(dmem_req), 32'(r.req));
                chk("MEM_STALL", 32'(MEM_STALL), 32'(r.stall));
                if (r.req) begin
                    chk("dmem_we", 32'(dmem_we), 32'(r.we));
                    chk("dmem_be", 32'(dmem_be), 32'(r.be));
                    chk("dmem_addr", dmem_addr, r.addr);
                    if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
                end
                @(negedge clk);
                #1;
                chk("WB_ALU_OUT", WB_ALU_OUT, r.alu);
                chk("WB_MEM_OUT", WB_MEM_OUT, r.mo);
                chk("WB_PC", WB_PC, r.pc);
                chk("WB_INST", WB_INST, r.inst);
                chk("WB_rd_ind", 32'(WB_rd_ind), 32'(r.rd));
                chk("WB_regwrite", 32'(WB_regwrite), 32'(r.rw));
                chk("WB_memread", 32'(WB_memread), 32'(r.mr));
                chk("MEM_EXC", 32'(MEM_EXC), 32'(r.exc));
            end
        end
    end

    // kind: 0 = ALU op, 1 = load, 2 = store. lat = cycles before ack for an issued access.
    task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int lat,
                         input logic rw);
        logic        load, store, legal, bad, req;
        logic [31:0] mask, val, wd, inst, pc;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic [6:0]  opc;
        int          nb, lane, n;
        rec_t        r;
        load  = (kind == 1);
        store = (kind == 2);
        legal = store ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        lane  = int'(addr % 4);
        bad   = (load || store) && (!legal || (addr % nb) != 0);
        req   = (load || store) && !bad;
        mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
        val   = (rdata >> (8 * lane)) & mask;
        if (f3 < 3'd4 && nb < 4 && val >= (32'd1 << (8 * nb - 1)))
            val = val - (32'd1 << (8 * nb));
        be    = store ? 4'((((1 << nb) - 1) << lane) & 15) : 4'hF;
        wd    = (nb == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
                (nb == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
        opc   = load ? 7'b0000011 : store ? 7'b0100011 : 7'b0110011;
        inst  = ($urandom & 32'hFFFF_8F80) | (32'(f3) << 12) | 32'(opc);
        pc    = $urandom;
        rd    = 5'($urandom);
        n     = req ? lat : 0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            #2;
            if (k == 0) begin
                MEM_ALU_OUT  = addr;
                MEM_rs2      = rs2;
                MEM_rd_ind   = rd;
                MEM_PC       = pc;
                MEM_INST     = inst;
                MEM_opcode   = opc;
                MEM_memread  = load;
                MEM_memwrite = store;
                MEM_regwrite = rw;
            end
            dmem_ack   = req ? (k == n) : 1'($urandom);
            dmem_rdata = (k == n) ? rdata : $urandom;
            r.req   = req;
            r.stall = req && (k < n);
            r.we    = store;
            r.be    = be;
            r.wdata = wd;
            r.addr  = addr & 32'hFFFF_FFFC;
            if (r.stall) begin
                r.alu = 0; r.mo = 0; r.pc = 0; r.inst = 0; r.rd = 0;
                r.rw = 0; r.mr = 0; r.exc = 0;
            end else begin
                r.alu  = addr;
                r.mo   = (load && !bad) ? val : 32'h0;
                r.pc   = pc;
                r.inst = inst;
                r.rd   = rd;
                r.rw   = rw && !bad && !store;
                r.mr   = load && !bad;
                r.exc  = bad;
            end
            q.push_back(r);
        end
    endtask

    function automatic logic [2:0] pick_f3(input int kind);
        logic [2:0] legal_ld[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if ($urandom_range(0, 9) < 2) return 3'($urandom);
        if (kind == 2) return 3'($urandom_range(0, 2));
        return legal_ld[$urandom_range(0, 4)];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        MEM_ALU_OUT = 0; MEM_rs2 = 0; MEM_rd_ind = 0; MEM_PC = 0; MEM_INST = 0;
        MEM_opcode = 0; MEM_memread = 0; MEM_memwrite = 0; MEM_regwrite = 0;
        dmem_ack = 0; dmem_rdata = 0;
        #3;
        chk("rst_WB_ALU_OUT", WB_ALU_OUT, 32'h0);
        chk("rst_WB_regwrite", 32'(WB_regwrite), 32'h0);
        chk("rst_MEM_EXC", 32'(MEM_EXC), 32'h0);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        #19 rst = 1'b1;

        issue(1, 3'd0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 1'b1);
        issue(1, 3'd5, 32'h0000_2002, 32'h0, 32'h8001_1234, 3, 1'b1);
        issue(2, 3'd0, 32'h0000_0001, 32'h1234_56AB, 32'h0, 0, 1'b1);
        issue(1, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 0, 1'b1);
        issue(0, 3'd0, 32'h0000_0055, 32'h0, 32'h0, 0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            issue(kind, pick_f3(kind), a, $urandom, $urandom, $urandom_range(0, 3),
                  1'($urandom));
        end

        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        // Async reset in the middle of an outstanding request.
        MEM_ALU_OUT = 32'h77; MEM_opcode = 7'b0110011; MEM_INST = 32'h0000_0033;
        MEM_memread = 0; MEM_memwrite = 0; MEM_regwrite = 1; dmem_ack = 0;
        @(negedge clk); #1;
        chk("rst_pre_commit", WB_ALU_OUT, 32'h77);
        #1;
        MEM_ALU_OUT = 32'h100; MEM_opcode = 7'b0000011; MEM_INST = 32'h0000_2003;
        MEM_memread = 1;
        @(posedge clk); #1;
        chk("rst_pre_stall", 32'(MEM_STALL), 32'h1);
        @(negedge clk); @(posedge clk); #1;
        chk("wait_stall", 32'(MEM_STALL), 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_req_drop", 32'(dmem_req), 32'h0);
        chk("rst_stall_drop", 32'(MEM_STALL), 32'h0);
        chk("rst_wb_pc", WB_PC, 32'h0);
        chk("rst_exc", 32'(MEM_EXC), 32'h0);
        @(negedge clk); #2;
        rst = 1'b1;
        MEM_ALU_OUT = 32'h99; MEM_opcode = 7'b0110011; MEM_INST = 32'h0000_0033;
        MEM_memread = 0;
        #1;
        chk("post_rst_idle_req", 32'(dmem_req), 32'h0);
        @(negedge clk); #1;
        chk("post_rst_alu", WB_ALU_OUT, 32'h99);
        #1;
        MEM_ALU_OUT = 32'h200; MEM_opcode = 7'b0000011; MEM_INST = 32'h0000_2003;
        MEM_memread = 1; dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("post_rst_lw_req", 32'(dmem_req), 32'h1);
        chk("post_rst_lw_stall", 32'(MEM_STALL), 32'h0);
        @(negedge clk); #1;
        chk("post_rst_lw_data", WB_MEM_OUT, 32'hCAFE_F00D);
        chk("post_rst_lw_rw", 32'(WB_regwrite), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
